// File: rtl/snake_pkg.sv
// Shared encodings and helpers for the snake game sequencing controller.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DEAD = 2'b10
    } state_t;

    localparam int PER_W = 16;

    // Opposite pairs differ only in bit 0 (up/down, left/right).
    function automatic logic is_opposite(input dir_t a, input dir_t b);
        return (a ^ b) == 2'b01;
    endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Game-step tick counter: counts 0..period-1 and strobes wrap on the last count.
module snake_tick_gen
    import snake_pkg::*;
(
    input  logic             slw_clk,
    input  logic             reset,
    input  logic [PER_W-1:0] period,
    input  logic             clear,
    input  logic             enable,
    output logic             wrap
);

    logic [PER_W-1:0] r_cnt;
    logic [PER_W-1:0] r_per;

    assign wrap = enable && (r_cnt == r_per - PER_W'(1));

    // The period is latched only at clear/wrap so a change never truncates a running step.
    always_ff @(posedge slw_clk) begin
        if (reset || clear) begin
            r_cnt <= '0;
            r_per <= period;
        end else if (enable) begin
            if (wrap) begin
                r_cnt <= '0;
                r_per <= period;
            end else begin
                r_cnt <= r_cnt + PER_W'(1);
            end
        end
    end

endmodule

// File: rtl/snake_step_ctrl.sv
// Snake game sequencer: direction arbitration, step strobe, game FSM and score.
// Optional step-period speed-up with score is enabled by defining SNAKE_SPEEDUP_EN.
module snake_step_ctrl
    import snake_pkg::*;
#(
    parameter int TICK_DIV   = 16,
    parameter int MIN_DIV    = 4,
    parameter int SPEED_STEP = 1,
    parameter int SCORE_W    = 8
) (
    input  logic               slw_clk,
    input  logic               reset,
    input  logic               up,
    input  logic               down,
    input  logic               left,
    input  logic               right,
    input  logic               hit,
    input  logic               eat,
    output logic               step,
    output logic [1:0]         dir,
    output logic               restart,
    output logic [1:0]         game_state,
    output logic [SCORE_W-1:0] score
);

    state_t             r_state, w_state_n;
    dir_t               r_dir, w_dir_n;
    dir_t               r_pend, w_pend_n;
    logic [SCORE_W-1:0] r_score, w_score_n;
    logic               r_step, w_step_n;
    logic               r_restart, w_restart_n;
    logic               r_press_prev;

    logic               w_press;
    dir_t               w_btn;
    logic               w_accept;
    logic               w_clear;
    logic               w_enable;
    logic               w_wrap;
    logic [PER_W-1:0]   w_period;

    assign w_press = up | down | left | right;

    always_comb begin
        w_btn = DIR_RIGHT;
        if (up)
            w_btn = DIR_UP;
        else if (down)
            w_btn = DIR_DOWN;
        else if (left)
            w_btn = DIR_LEFT;
    end

    assign w_accept = w_press && !is_opposite(w_btn, r_dir);

`ifdef SNAKE_SPEEDUP_EN
    localparam int PW = SCORE_W + 16;
    logic [SCORE_W-1:0] w_score_eff;
    logic [PW-1:0]      w_dec;
    // In IDLE the score is about to be cleared, so the period loaded at game start uses zero.
    assign w_score_eff = (r_state == ST_IDLE) ? '0 : r_score;
    assign w_dec       = PW'(w_score_eff) * PW'(SPEED_STEP);
    assign w_period    = (w_dec >= PW'(TICK_DIV - MIN_DIV)) ? PER_W'(MIN_DIV)
                                                            : PER_W'(PW'(TICK_DIV) - w_dec);
`else
    assign w_period = PER_W'(TICK_DIV);
`endif

    snake_tick_gen u_tick (
        .slw_clk (slw_clk),
        .reset   (reset),
        .period  (w_period),
        .clear   (w_clear),
        .enable  (w_enable),
        .wrap    (w_wrap)
    );

    always_comb begin
        w_state_n   = r_state;
        w_dir_n     = r_dir;
        w_pend_n    = r_pend;
        w_score_n   = r_score;
        w_step_n    = 1'b0;
        w_restart_n = 1'b0;
        w_clear     = 1'b0;
        w_enable    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_press) begin
                    w_state_n   = ST_RUN;
                    w_restart_n = 1'b1;
                    w_score_n   = '0;
                    w_clear     = 1'b1;
                    w_dir_n     = DIR_RIGHT;
                    w_pend_n    = (w_btn == DIR_LEFT) ? DIR_RIGHT : w_btn;
                end
            end
            ST_RUN: begin
                w_enable = 1'b1;
                if (hit) begin
                    w_state_n = ST_DEAD;
                end else begin
                    if (eat && (r_score != '1))
                        w_score_n = r_score + SCORE_W'(1);
                    if (w_accept)
                        w_pend_n = w_btn;
                    // A press landing on the wrap cycle is forwarded straight into this step.
                    if (w_wrap) begin
                        w_step_n = 1'b1;
                        w_dir_n  = w_accept ? w_btn : r_pend;
                    end
                end
            end
            ST_DEAD: begin
                if (w_press && !r_press_prev)
                    w_state_n = ST_IDLE;
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge slw_clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_dir        <= DIR_RIGHT;
            r_pend       <= DIR_RIGHT;
            r_score      <= '0;
            r_step       <= 1'b0;
            r_restart    <= 1'b0;
            r_press_prev <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_dir        <= w_dir_n;
            r_pend       <= w_pend_n;
            r_score      <= w_score_n;
            r_step       <= w_step_n;
            r_restart    <= w_restart_n;
            r_press_prev <= w_press;
        end
    end

    assign step       = r_step;
    assign dir        = r_dir;
    assign restart    = r_restart;
    assign game_state = r_state;
    assign score      = r_score;

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Directed self-checking bench for snake_step_ctrl (TICK_DIV=4, SCORE_W=3, default build).
module tb_snake_step_ctrl;

    logic       slw_clk;
    logic       reset;
    logic       up, down, left, right;
    logic       hit, eat;
    logic       step;
    logic [1:0] dir;
    logic       restart;
    logic [1:0] game_state;
    logic [2:0] score;

    int n_vec;
    int n_err;

    snake_step_ctrl #(
        .TICK_DIV (4),
        .SCORE_W  (3)
    ) dut (
        .slw_clk    (slw_clk),
        .reset      (reset),
        .up         (up),
        .down       (down),
        .left       (left),
        .right      (right),
        .hit        (hit),
        .eat        (eat),
        .step       (step),
        .dir        (dir),
        .restart    (restart),
        .game_state (game_state),
        .score      (score)
    );

    initial slw_clk = 1'b0;
    always #5 slw_clk = ~slw_clk;

    task automatic tick();
        @(posedge slw_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        {up, down, left, right, hit, eat} = '0;
        tick();
        tick();
        chk("rst_state", 8'(game_state), 8'h0);
        chk("rst_dir", 8'(dir), 8'h3);
        chk("rst_step", 8'(step), 8'h0);
        chk("rst_restart", 8'(restart), 8'h0);
        chk("rst_score", 8'(score), 8'h0);
        reset = 1'b0;
        tick();
        chk("idle_hold", 8'(game_state), 8'h0);

        // Start game with up; entry cycle is c=0.
        up = 1'b1;
        tick();
        up = 1'b0;
        chk("start_state", 8'(game_state), 8'h1);
        chk("start_restart", 8'(restart), 8'h1);
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk("run_step", 8'(step), (c % 4 == 0) ? 8'h1 : 8'h0);
            if (c == 1) chk("restart_once", 8'(restart), 8'h0);
            if (c == 4) chk("first_dir_up", 8'(dir), 8'h0);
        end

        // Turn right (c=12 press), step at c=16.
        right = 1'b1;
        tick();
        right = 1'b0;
        for (int c = 14; c <= 16; c++) tick();
        chk("turn_right_step", 8'(step), 8'h1);
        chk("turn_right_dir", 8'(dir), 8'h3);

        // up at c=16, then left held: left rejected against committed right.
        up = 1'b1;
        tick();
        up = 1'b0;
        left = 1'b1;
        for (int c = 18; c <= 20; c++) tick();
        chk("no_reverse_step", 8'(step), 8'h1);
        chk("no_reverse_dir", 8'(dir), 8'h0);
        tick();
        left = 1'b0;
        for (int c = 22; c <= 24; c++) tick();
        chk("left_after_up_step", 8'(step), 8'h1);
        chk("left_after_up_dir", 8'(dir), 8'h2);

        // Hold right (reverse of left) for 3 periods.
        right = 1'b1;
        for (int c = 25; c <= 36; c++) begin
            tick();
            chk("hold_rev_step", 8'(step), (c % 4 == 0) ? 8'h1 : 8'h0);
            chk("hold_rev_dir", 8'(dir), 8'h2);
        end
        right = 1'b0;

        // Five eat pulses -> score 5 at c=41.
        eat = 1'b1;
        for (int c = 37; c <= 41; c++) tick();
        eat = 1'b0;
        chk("score_5", 8'(score), 8'h5);
        tick();
        tick();

        // c=43 is a wrap cycle: hit+eat together with a held button.
        hit = 1'b1;
        eat = 1'b1;
        right = 1'b1;
        tick();
        hit = 1'b0;
        eat = 1'b0;
        chk("dead_state", 8'(game_state), 8'h2);
        chk("dead_suppress_step", 8'(step), 8'h0);
        chk("dead_score", 8'(score), 8'h5);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("dead_no_step", 8'(step), 8'h0);
            chk("dead_held", 8'(game_state), 8'h2);
            chk("dead_dir", 8'(dir), 8'h2);
        end
        right = 1'b0;
        tick();
        chk("dead_release", 8'(game_state), 8'h2);
        down = 1'b1;
        tick();
        down = 1'b0;
        chk("dead_to_idle", 8'(game_state), 8'h0);

        // Start with left: pending stays right; score saturates at 7.
        left = 1'b1;
        tick();
        left = 1'b0;
        eat = 1'b1;
        chk("restart2_state", 8'(game_state), 8'h1);
        chk("restart2_pulse", 8'(restart), 8'h1);
        chk("restart2_score", 8'(score), 8'h0);
        chk("restart2_dir", 8'(dir), 8'h3);
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 4) begin
                chk("idle_left_step", 8'(step), 8'h1);
                chk("idle_left_dir", 8'(dir), 8'h3);
            end
        end
        eat = 1'b0;
        chk("score_sat", 8'(score), 8'h7);

        // Reset mid-period.
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_state", 8'(game_state), 8'h0);
        chk("mid_rst_score", 8'(score), 8'h0);
        chk("mid_rst_dir", 8'(dir), 8'h3);
        chk("mid_rst_step", 8'(step), 8'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("post_rst_idle_step", 8'(step), 8'h0);
            chk("post_rst_idle_state", 8'(game_state), 8'h0);
        end
        up = 1'b1;
        tick();
        up = 1'b0;
        chk("post_rst_restart", 8'(restart), 8'h1);
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk("post_rst_step", 8'(step), (c == 4) ? 8'h1 : 8'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
